// File: rtl/seg_bus_monitor.sv
// Loopback reader for a multiplexed common-anode 7-segment bus: waits for each digit's
// pattern to settle, decodes it back to hex and keeps a per-digit register file.
module seg_bus_monitor #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [N_DIGITS-1:0]   an_n,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   valid_mask,
    output logic                  cap_valid,
    output logic [2:0]            cap_idx,
    output logic [3:0]            cap_value,
    output logic                  cap_invalid,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W:0]   CNT_TGT = (CNT_W + 1)'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_HOLD
    } state_t;

    // Returns {hit, value}; hit=0 for blank and for anything outside the hex table.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'b0111111: seg_decode = {1'b1, 4'h0};
            7'b0000110: seg_decode = {1'b1, 4'h1};
            7'b1011011: seg_decode = {1'b1, 4'h2};
            7'b1001111: seg_decode = {1'b1, 4'h3};
            7'b1100110: seg_decode = {1'b1, 4'h4};
            7'b1101101: seg_decode = {1'b1, 4'h5};
            7'b1111101: seg_decode = {1'b1, 4'h6};
            7'b0000111: seg_decode = {1'b1, 4'h7};
            7'b1111111: seg_decode = {1'b1, 4'h8};
            7'b1101111: seg_decode = {1'b1, 4'h9};
            7'b1110111: seg_decode = {1'b1, 4'hA};
            7'b1111100: seg_decode = {1'b1, 4'hB};
            7'b0111001: seg_decode = {1'b1, 4'hC};
            7'b1011110: seg_decode = {1'b1, 4'hD};
            7'b1111001: seg_decode = {1'b1, 4'hE};
            7'b1110001: seg_decode = {1'b1, 4'hF};
            default:    seg_decode = 5'b0;
        endcase
    endfunction

    logic [6:0]            r_seg_p0;
    logic [N_DIGITS-1:0]   r_an_p0;
    state_t                r_state;
    state_t                w_state_nx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nx;
    logic [CNT_W:0]        w_cnt_inc;
    logic [6:0]            r_ref_seg;
    logic [6:0]            w_ref_seg_nx;
    logic [N_DIGITS-1:0]   r_ref_an;
    logic [N_DIGITS-1:0]   w_ref_an_nx;
    logic [N_DIGITS-1:0]   w_an_act;
    logic                  w_legal;
    logic                  w_same;
    logic                  w_start;
    logic                  w_cap;
    logic [2:0]            w_idx;
    logic [6:0]            w_p;
    logic [4:0]            w_dec;
    logic                  w_blank;
    logic [N_DIGITS-1:0]   r_seen;
    logic [N_DIGITS-1:0]   w_seen_nx;
    logic [4*N_DIGITS-1:0] r_digits;
    logic [N_DIGITS-1:0]   r_valid_mask;
    logic                  r_cap_valid;
    logic [2:0]            r_cap_idx;
    logic [3:0]            r_cap_value;
    logic                  r_cap_invalid;
    logic                  r_frame_done;

    // Stage p0: register the raw bus; reset parks it on "no anode" so tracking restarts cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_p0 <= '1;
            r_an_p0  <= '1;
        end else begin
            r_seg_p0 <= seg_n;
            r_an_p0  <= an_n;
        end
    end

    always_comb begin
        w_an_act = ~r_an_p0;
        w_legal  = ($countones(w_an_act) == 1);
        w_idx    = 3'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_an_act[i]) begin
                w_idx = 3'(i);
            end
        end
        w_p       = ~r_seg_p0;
        w_dec     = seg_decode(w_p);
        w_blank   = (w_p == 7'b0);
        w_seen_nx = r_seen | w_an_act;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_ref_seg_nx = r_ref_seg;
        w_ref_an_nx  = r_ref_an;
        w_cap        = 1'b0;
        w_same       = (r_an_p0 == r_ref_an) && (r_seg_p0 == r_ref_seg);
        w_start      = (r_state == ST_IDLE) || !w_same;
        w_cnt_inc    = {1'b0, r_cnt} + (CNT_W + 1)'(1);
        if (!w_legal) begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
        end else if (w_start) begin
            w_ref_seg_nx = r_seg_p0;
            w_ref_an_nx  = r_an_p0;
            if (STABLE_CYCLES == 1) begin
                w_cap      = 1'b1;
                w_state_nx = ST_HOLD;
                w_cnt_nx   = CNT_SAT;
            end else begin
                w_state_nx = ST_TRACK;
                w_cnt_nx   = CNT_ONE;
            end
        end else if (r_state == ST_TRACK) begin
            if (w_cnt_inc >= CNT_TGT) begin
                w_cap      = 1'b1;
                w_state_nx = ST_HOLD;
                w_cnt_nx   = CNT_SAT;
            end else begin
                w_cnt_nx = w_cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ref_seg <= '0;
            r_ref_an  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_ref_seg <= w_ref_seg_nx;
            r_ref_an  <= w_ref_an_nx;
        end
    end

    // Stage p1: capture into the register file and emit the event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digits      <= '0;
            r_valid_mask  <= '0;
            r_seen        <= '0;
            r_cap_valid   <= 1'b0;
            r_cap_invalid <= 1'b0;
            r_cap_idx     <= '0;
            r_cap_value   <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_cap_valid   <= 1'b0;
            r_cap_invalid <= 1'b0;
            r_frame_done  <= 1'b0;
            if (w_cap) begin
                if (w_dec[4]) begin
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if (w_an_act[i]) begin
                            r_digits[4*i +: 4] <= w_dec[3:0];
                        end
                    end
                    r_valid_mask <= r_valid_mask | w_an_act;
                    r_cap_valid  <= 1'b1;
                    r_cap_idx    <= w_idx;
                    r_cap_value  <= w_dec[3:0];
                end else begin
                    r_valid_mask <= r_valid_mask & ~w_an_act;
                    if (!w_blank) begin
                        r_cap_invalid <= 1'b1;
                        r_cap_idx     <= w_idx;
                    end
                end
                // The completing capture closes the frame; it does not count toward the next one.
                if (w_seen_nx == '1) begin
                    r_frame_done <= 1'b1;
                    r_seen       <= '0;
                end else begin
                    r_seen <= w_seen_nx;
                end
            end
        end
    end

    assign digits      = r_digits;
    assign valid_mask  = r_valid_mask;
    assign cap_valid   = r_cap_valid;
    assign cap_idx     = r_cap_idx;
    assign cap_value   = r_cap_value;
    assign cap_invalid = r_cap_invalid;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg_bus_monitor.sv
// Directed bench for seg_bus_monitor (N_DIGITS=4, STABLE_CYCLES=4) with hand-computed expectations.
module tb_seg_bus_monitor;

    localparam int N = 4;
    localparam int S = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     seg_n;
    logic [N-1:0]   an_n;
    logic [4*N-1:0] digits;
    logic [N-1:0]   valid_mask;
    logic           cap_valid;
    logic [2:0]     cap_idx;
    logic [3:0]     cap_value;
    logic           cap_invalid;
    logic           frame_done;

    int checks = 0;
    int errors = 0;

    // Active-high patterns {g,f,e,d,c,b,a} for hex 0..F.
    logic [6:0] tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int         nv, ni, nf, t_pulse;
    logic [2:0] p_idx;
    logic [3:0] p_val;
    logic       p_fd;

    seg_bus_monitor #(
        .N_DIGITS      (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .digits      (digits),
        .valid_mask  (valid_mask),
        .cap_valid   (cap_valid),
        .cap_idx     (cap_idx),
        .cap_value   (cap_value),
        .cap_invalid (cap_invalid),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs n edges, counting pulses and recording the last capture event.
    task automatic window(input int n);
        nv = 0; ni = 0; nf = 0; t_pulse = 0;
        p_idx = '0; p_val = '0; p_fd = 1'b0;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (cap_valid)   nv++;
            if (cap_invalid) ni++;
            if (frame_done)  nf++;
            if (cap_valid || cap_invalid) begin
                t_pulse = t;
                p_idx   = cap_idx;
                p_val   = cap_value;
                p_fd    = frame_done;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        seg_n = 7'h7F;
        an_n  = 4'hF;
        tick();
        tick();
        chk("rst_digits", digits, 0);
        chk("rst_mask", valid_mask, 0);
        chk("rst_pulses", {cap_valid, cap_invalid, frame_done}, 0);
        chk("rst_idx_val", {cap_idx, cap_value}, 0);
        rst = 1'b0;
        tick();
        tick();

        // Single digit "3" on digit 0, then held.
        an_n  = 4'b1110;
        seg_n = 7'b0110000;
        window(5);
        chk("t1_nv", nv, 1);
        chk("t1_edge", t_pulse, 5);
        chk("t1_idx", p_idx, 0);
        chk("t1_val", p_val, 3);
        chk("t1_digit0", digits[3:0], 3);
        chk("t1_mask", valid_mask, 4'b0001);
        window(20);
        chk("t1_hold_quiet", nv + ni + nf, 0);

        // Pattern change after 2 cycles restarts the count.
        seg_n = ~tab[5];
        window(2);
        chk("t2_short_quiet", nv + ni, 0);
        seg_n = ~tab[7];
        window(6);
        chk("t2_nv", nv, 1);
        chk("t2_edge", t_pulse, 5);
        chk("t2_val", p_val, 7);
        chk("t2_digit0", digits[3:0], 7);

        // Scan 1,2,4,8 across digits 0..3; digit 3 completes the frame.
        for (int d = 0; d < 4; d++) begin
            an_n  = ~(4'b0001 << d);
            seg_n = ~tab[1 << d];
            window(6);
            chk("t3_nv", nv, 1);
            chk("t3_edge", t_pulse, 5);
            chk("t3_idx", p_idx, d);
            chk("t3_val", p_val, 1 << d);
            chk("t3_fd", {nf, 31'(p_fd)}, (d == 3) ? {32'd1, 31'd1} : 0);
        end
        chk("t3_digits", digits, 16'h8421);
        chk("t3_mask", valid_mask, 4'b1111);

        // Non-table pattern on digit 2.
        an_n  = 4'b1011;
        seg_n = ~7'b1010101;
        window(6);
        chk("t4_ni", ni, 1);
        chk("t4_nv", nv, 0);
        chk("t4_edge", t_pulse, 5);
        chk("t4_idx", p_idx, 2);
        chk("t4_mask", valid_mask, 4'b1011);
        chk("t4_digits", digits, 16'h8421);
        chk("t4_val_held", cap_value, 8);

        // Two anodes low: no activity.
        an_n  = 4'b0011;
        seg_n = ~tab[2];
        window(10);
        chk("t4_illegal_quiet", nv + ni + nf, 0);

        // Blank on digit 2, then on digit 1 (clears a valid digit).
        an_n  = 4'b1011;
        seg_n = 7'h7F;
        window(8);
        chk("t4_blank2_quiet", nv + ni + nf, 0);
        chk("t4_blank2_mask", valid_mask, 4'b1011);
        an_n = 4'b1101;
        window(8);
        chk("t4_blank1_quiet", nv + ni + nf, 0);
        chk("t4_blank1_mask", valid_mask, 4'b1001);
        chk("t4_blank1_digits", digits, 16'h8421);

        // Full decode sweep on digit 1.
        for (int v = 0; v < 16; v++) begin
            an_n  = 4'b1101;
            seg_n = ~tab[v];
            window(6);
            chk("t5_nv_idx", {nv[7:0], 5'(p_idx)}, {8'd1, 5'd1});
            chk("t5_val", p_val, v);
        end
        an_n  = 4'b1101;
        seg_n = ~7'b1111001;
        window(6);
        chk("t5_E", p_val, 4'hE);
        seg_n = ~7'b0111001;
        window(6);
        chk("t5_C", p_val, 4'hC);
        chk("t5_digits", digits, 16'h84C1);
        chk("t5_mask", valid_mask, 4'b1011);

        // Reset lands on the capture edge.
        an_n  = 4'b0111;
        seg_n = ~tab[5];
        window(4);
        chk("t6_pre_quiet", nv + ni, 0);
        rst = 1'b1;
        tick();
        chk("t6_rst_digits", digits, 0);
        chk("t6_rst_mask", valid_mask, 0);
        chk("t6_rst_pulses", {cap_valid, cap_invalid, frame_done}, 0);
        chk("t6_rst_idx_val", {cap_idx, cap_value}, 0);
        rst = 1'b0;
        window(6);
        chk("t6_nv", nv, 1);
        chk("t6_edge", t_pulse, 5);
        chk("t6_idx", p_idx, 3);
        chk("t6_val", p_val, 5);
        chk("t6_digits", digits, 16'h5000);
        chk("t6_mask", valid_mask, 4'b1000);
        chk("t6_nf", nf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_bus_monitor.md
Name: seg_bus_monitor

Overview:
- Reader for the multiplexed common-anode 7-segment display bus driven by the display path.
- Samples the active-low segment and anode lines and waits for each digit's pattern to settle.
- Converts each settled pattern back to a 4-bit hex value and keeps a per-digit register file.
- Used for on-chip loopback checking of the displayed (corrected) word against the source word.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (anode lines); 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before capture; 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- seg_n  input  7  segment lines, active-low, bit0=a … bit6=g.
- an_n  input  N_DIGITS  anode selects, active-low, one digit enabled at a time.
- digits  output  4*N_DIGITS  captured hex values, digit i at [4i+3:4i].
- valid_mask  output  N_DIGITS  bit i=1: digits[i] holds a decoded value.
- cap_valid  output  1  1-cycle pulse: a legal pattern was captured.
- cap_idx  output  3  digit index of the latest capture (valid with cap_valid/cap_invalid).
- cap_value  output  4  decoded value (valid with cap_valid).
- cap_invalid  output  1  1-cycle pulse: a stable non-table, non-blank pattern was captured.
- frame_done  output  1  1-cycle pulse: every digit was captured at least once since the last pulse.

Behaviour:
- Reset: all outputs 0; digits=0; valid_mask=0; seen mask=0; state IDLE; counter=0. rst wins over any same-cycle capture.
- Input stage: seg_n/an_n registered once. All logic below operates on the registered pair (an,seg).
- Anode legality: legal only when exactly one an_n bit is 0. idx = position of that bit.
- Illegal anode (none or several low): state goes to IDLE, counter cleared, no capture.
- States:
  - IDLE: on a legal pair, go to TRACK with counter=1 and store the pair as ref.
  - TRACK: if the pair equals ref, counter++. If the pair differs and is legal, ref=new pair and counter=1. If illegal, go to IDLE.
  - Capture from TRACK: when the counter would reach STABLE_CYCLES, capture and go to HOLD. With STABLE_CYCLES=1, capture on the first TRACK entry, going IDLE→HOLD directly.
  - HOLD: no further captures while the pair equals ref. A different legal pair goes to TRACK with counter=1. An illegal pair goes to IDLE.
- Latency: pins held constant from cycle 0 give a capture pulse registered at clock edge STABLE_CYCLES+1.
- Decode: p=~seg (active-high), p[6:0]={g,f,e,d,c,b,a}.
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Table hit: digits[idx]=value, valid_mask[idx]=1, seen[idx]=1, pulse cap_valid with cap_idx/cap_value.
- Blank (p=0000000): valid_mask[idx]=0, seen[idx]=1, digits[idx] unchanged, no pulse.
- Other pattern: valid_mask[idx]=0, seen[idx]=1, digits[idx] unchanged, pulse cap_invalid with cap_idx.
- frame_done: asserted in the same cycle as the capture that completes seen=all-ones. seen clears in that cycle, and the completing index is not pre-set for the next frame.
- Re-capture of an already-seen index: updates registers and pulses as above, seen unchanged.
- cap_valid and cap_invalid are never high together. cap_idx/cap_value hold their last values between pulses.
- Counter width: clog2(STABLE_CYCLES+1); saturates at STABLE_CYCLES (no wrap) while in HOLD.

Test Plan:
- Reset, then an_n=1110, seg_n=~0110000 (=1001111 pattern "3"), STABLE_CYCLES=4 → cap_valid at edge 5, cap_idx=0, cap_value=3, digits[3:0]=3, valid_mask=0001; no further pulse while held for 20 cycles.
- Same pair with seg_n changed to another legal pattern after 2 cycles → counter restarts; single cap_valid 5 edges after the change with the new value.
- Scan digits 0..3 with 1,2,4,8 for 6 cycles each → four cap_valid pulses; frame_done with the idx=3 capture; digits=0x8421; valid_mask=1111.
- p=1010101 on digit 2 → cap_invalid, cap_idx=2, valid_mask[2]=0, digits[2] unchanged. Then an_n=0011 for 10 cycles → no pulses, IDLE. Then blank on digit 2 → no pulse, valid_mask[2]=0.
- Full decode sweep: all 16 table patterns on digit 1 → cap_value equals the table index; 1111001→E and 0111001→C.
- Assert rst during the capture cycle → all outputs 0 next cycle, no pulse; the bench then holds the same pair and sees a capture STABLE_CYCLES+1 edges after rst deasserts.
